// File: rtl/alu_result_log_if.sv
// Handshake bundle between the ALU result stream, the scroll buttons and the
// history display path of alu_result_log.
interface alu_result_log_if #(
    parameter int DATA_W = 8,
    parameter int PTR_W  = 3
);
    logic              capture;
    logic [DATA_W-1:0] data_in;
    logic              clear;
    logic              older;
    logic              newer;
    logic [DATA_W-1:0] view_data;
    logic [PTR_W-1:0]  view_index;
    logic [PTR_W:0]    count;
    logic              full;
    logic              overwrote;

    modport master (
        output capture, data_in, clear, older, newer,
        input  view_data, view_index, count, full, overwrote
    );

    modport slave (
        input  capture, data_in, clear, older, newer,
        output view_data, view_index, count, full, overwrote
    );
endinterface

// File: rtl/alu_result_log.sv
// Circular history of the last DEPTH ALU results, with button-driven scrolling
// back and forward through the entries for the HEX/LEDR display path.
module alu_result_log #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input logic            clk,
    input logic            rst,
    alu_result_log_if.slave bus
);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  view_index;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              overwrote;
    logic              older_q;
    logic              newer_q;
    logic              step_old;
    logic              step_new;

    assign step_old = bus.older & ~older_q;
    assign step_new = bus.newer & ~newer_q;

    // Storage has no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (bus.capture && !bus.clear) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            count      <= '0;
            view_index <= '0;
            overwrote  <= 1'b0;
            older_q    <= 1'b0;
            newer_q    <= 1'b0;
        end else begin
            older_q <= bus.older;
            newer_q <= bus.newer;
            if (bus.clear) begin
                wr_ptr     <= '0;
                count      <= '0;
                view_index <= '0;
                overwrote  <= 1'b0;
            end else if (bus.capture) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                view_index <= '0;
                if (count == FULL_COUNT) begin
                    overwrote <= 1'b1;
                end else begin
                    count <= count + (PTR_W + 1)'(1);
                end
            end else if (step_old && !step_new) begin
                // Saturate at the oldest valid entry (count-1); no-op when empty.
                if ((PTR_W + 1)'(view_index) + (PTR_W + 1)'(1) < count) begin
                    view_index <= view_index + PTR_W'(1);
                end
            end else if (step_new && !step_old) begin
                if (view_index != '0) begin
                    view_index <= view_index - PTR_W'(1);
                end
            end
        end
    end

    assign rd_ptr         = wr_ptr - PTR_W'(1) - view_index;
    assign bus.view_data  = (count == '0) ? '0 : mem[rd_ptr];
    assign bus.view_index = view_index;
    assign bus.count      = count;
    assign bus.full       = (count == FULL_COUNT);
    assign bus.overwrote  = overwrote;
endmodule
